// File: rtl/ram_arbiter_pkg.sv
//------------------------------------------------------------------------------
// ram_arbiter_pkg : shared FSM state encodings and port identifiers
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_RESP   = 2'b10
  } arb_state_e;

  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_arb_priority_pick.sv
//------------------------------------------------------------------------------
// arb_priority_pick : combinational two-port winner selection
// Build option ARB_ROUND_ROBIN_EN: base priority alternates against last grant.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_priority_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  input  logic starve_i,
  output logic gnt_o
);

  logic w_base;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_base = ~last_gnt_i;
`else
  logic w_unused_last_gnt;
  assign w_unused_last_gnt = last_gnt_i;
  assign w_base            = ARB_PORT0;
`endif

  // A starved non-base port overrides base priority only on a genuine tie.
  always_comb begin
    gnt_o = ARB_PORT0;
    if (req0_i && req1_i) begin
      gnt_o = starve_i ? ~w_base : w_base;
    end else if (req1_i) begin
      gnt_o = ARB_PORT1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// ram_arbiter : serialises two masters onto one data RAM (IDLE/ACCESS/RESP)
// Build option ARB_ROUND_ROBIN_EN selects alternating tie priority.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  mem_wr_sig,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int              C_CW           = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [C_CW-1:0] C_WAIT_LIMIT   = C_CW'(WAIT_LIMIT);
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic            C_LAST_GNT_RST = ARB_PORT1;
`else
  localparam logic            C_LAST_GNT_RST = ARB_PORT0;
`endif

  arb_state_e            state_q,    state_d;
  logic                  gnt_q,      gnt_d;
  logic                  we_q,       we_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic                  m0_ack_q,   m0_ack_d;
  logic                  m1_ack_q,   m1_ack_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic [C_CW-1:0]       wait_q,     wait_d;
  logic                  last_gnt_q, last_gnt_d;

  logic w_any_req;
  logic w_starve;
  logic w_pick;

  assign w_any_req = m0_req | m1_req;
  assign w_starve  = (wait_q == C_WAIT_LIMIT);

  arb_priority_pick u_pick (
    .req0_i     (m0_req),
    .req1_i     (m1_req),
    .last_gnt_i (last_gnt_q),
    .starve_i   (w_starve),
    .gnt_o      (w_pick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= ARB_PORT0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      wait_q     <= '0;
      last_gnt_q <= C_LAST_GNT_RST;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      wait_q     <= wait_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    wait_d     = wait_q;
    last_gnt_d = last_gnt_q;

    case (state_q)
      ARB_IDLE: begin
        if (w_any_req) begin
          state_d    = ARB_ACCESS;
          gnt_d      = w_pick;
          last_gnt_d = w_pick;
          if (w_pick == ARB_PORT1) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
`ifdef ARB_ROUND_ROBIN_EN
          // A switch of owner means the other port was served; a repeat means it waited.
          if (m0_req && m1_req && (w_pick == last_gnt_q)) begin
            if (wait_q != C_WAIT_LIMIT) wait_d = wait_q + 1'b1;
          end else if (w_pick != last_gnt_q) begin
            wait_d = '0;
          end
`else
          if (m1_req && (w_pick == ARB_PORT0)) begin
            if (wait_q != C_WAIT_LIMIT) wait_d = wait_q + 1'b1;
          end else if (w_pick == ARB_PORT1) begin
            wait_d = '0;
          end
`endif
        end
      end
      ARB_ACCESS: begin
        state_d = ARB_RESP;
        if (gnt_q == ARB_PORT1) begin
          m1_ack_d = 1'b1;
          if (!we_q) m1_rdata_d = mem_rd_data;
        end else begin
          m0_ack_d = 1'b1;
          if (!we_q) m0_rdata_d = mem_rd_data;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Derived from state so an asynchronous reset removes the write strobe at once.
  assign mem_wr_sig  = (state_q == ARB_ACCESS) & we_q;
  assign mem_wr_data = wdata_q;
  assign mem_addr    = addr_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
//------------------------------------------------------------------------------
// tb_ram_arbiter : directed self-checking bench for ram_arbiter (fixed priority)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        mem_wr_sig;
  logic [31:0] mem_wr_data, mem_addr, mem_rd_data;
  logic [31:0] ram [0:255];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .WAIT_LIMIT (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m0_ack      (m0_ack),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .m1_ack      (m1_ack),
    .mem_wr_sig  (mem_wr_sig),
    .mem_wr_data (mem_wr_data),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on rising edge.
  assign mem_rd_data = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr_sig) ram[mem_addr[7:0]] <= mem_wr_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [10:0] exp_a0;
    logic [10:0] exp_a1;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    reset_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

    // Reset values
    tick(); tick();
    chk("rst_m0_ack", {31'b0, m0_ack}, 32'd0);
    chk("rst_m1_ack", {31'b0, m1_ack}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_wr_sig", {31'b0, mem_wr_sig}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wr_data, 32'd0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_wr_sig", {31'b0, mem_wr_sig}, 32'd0);
    chk("idle_acks", {30'b0, m1_ack, m0_ack}, 32'd0);

    // m0 write then read of 0x10
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    tick();
    chk("wr_access_wr_sig", {31'b0, mem_wr_sig}, 32'd1);
    chk("wr_access_addr", mem_addr, 32'h10);
    chk("wr_access_data", mem_wr_data, 32'hDEADBEEF);
    chk("wr_access_ack", {31'b0, m0_ack}, 32'd0);
    tick();
    chk("wr_resp_ack", {31'b0, m0_ack}, 32'd1);
    chk("wr_resp_wr_sig", {31'b0, mem_wr_sig}, 32'd0);
    tick();
    chk("wr_idle_ack", {31'b0, m0_ack}, 32'd0);
    chk("hold_mem_addr", mem_addr, 32'h10);
    m0_we = 0;
    tick();
    chk("rd_access_wr_sig", {31'b0, mem_wr_sig}, 32'd0);
    tick();
    chk("rd_ack", {31'b0, m0_ack}, 32'd1);
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    tick(); tick();
    chk("rd_after_ack", {31'b0, m0_ack}, 32'd0);
    chk("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Simultaneous writes: m0 first, m1 three cycles later
    m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h11;
    m1_req = 1; m1_we = 1; m1_addr = 32'h31; m1_wdata = 32'h22;
    tick();
    chk("tie_addr0", mem_addr, 32'h30);
    tick();
    chk("tie_acks_first", {30'b0, m1_ack, m0_ack}, 32'd1);
    m0_req = 0;
    tick(); tick();
    chk("tie_addr1", mem_addr, 32'h31);
    chk("tie_wdata1", mem_wr_data, 32'h22);
    tick();
    chk("tie_acks_second", {30'b0, m1_ack, m0_ack}, 32'd2);
    m1_req = 0;
    tick();

    // Continuous contention, WAIT_LIMIT=2: m0, m0, then m1 forced, then m0
    m0_req = 1; m0_we = 0; m0_addr = 32'h30;
    m1_req = 1; m1_we = 0; m1_addr = 32'h31;
    exp_a0 = 11'b100_0001_0010;
    exp_a1 = 11'b000_1000_0000;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("starve_m0_ack_%0d", i), {31'b0, m0_ack}, {31'b0, exp_a0[i]});
      chk($sformatf("starve_m1_ack_%0d", i), {31'b0, m1_ack}, {31'b0, exp_a1[i]});
      if (i == 1) chk("starve_m0_rdata", m0_rdata, 32'h11);
      if (i == 7) chk("starve_m1_rdata", m1_rdata, 32'h22);
    end
    m0_req = 0; m1_req = 0;
    tick();

    // Reset during m1 write ACCESS: strobe drops, no ack, old data kept
    m1_req = 1; m1_we = 1; m1_addr = 32'h31; m1_wdata = 32'h99;
    tick();
    chk("rstmid_wr_sig_before", {31'b0, mem_wr_sig}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_wr_sig_drop", {31'b0, mem_wr_sig}, 32'd0);
    m1_req = 0;
    tick(); tick();
    chk("rstmid_no_ack", {31'b0, m1_ack}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rstmid_idle_wr_sig", {31'b0, mem_wr_sig}, 32'd0);
    m1_req = 1; m1_we = 0; m1_addr = 32'h31;
    tick(); tick();
    chk("rstmid_read_ack", {31'b0, m1_ack}, 32'd1);
    chk("rstmid_old_data", m1_rdata, 32'h22);
    m1_req = 0;
    tick();

    // m0 writes 0x5 to 0x20, m1 reads it back
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h5;
    tick(); tick();
    chk("x_m0_wr_ack", {31'b0, m0_ack}, 32'd1);
    m0_req = 0;
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    tick();
    chk("x_m0_ack_quiet", {31'b0, m0_ack}, 32'd0);
    tick();
    chk("x_m1_ack", {31'b0, m1_ack}, 32'd1);
    chk("x_m1_rdata", m1_rdata, 32'h5);
    chk("x_m0_ack_still0", {31'b0, m0_ack}, 32'd0);
    m1_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
